// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 3-sample majority voting,
// framing/parity error flags, break detection and a small receive FIFO.
module uart_rx_cfg #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DATA_BITS + 2;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [15:0]   TMR_HALF = 16'(CLK_DIV / 2 + 1);
  localparam logic [15:0]   TMR_BIT  = 16'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_sync1, r_sync2;
  logic                 w_rx_s;
  logic [15:0]          r_timer;
  logic                 r_smp2, r_smp1;
  logic                 w_maj, w_tick, w_last_stop, w_brk;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit, r_par_err, r_ferr;
  logic                 r_wr_req;
  logic [EW-1:0]        r_wr_entry;
  logic                 r_break_det;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic                 w_pop, w_push, w_ovr, w_full;
  logic [EW-1:0]        r_head, w_head_nxt;
  logic                 r_valid, r_overrun;

  assign w_rx_s      = r_sync2;
  assign w_tick      = (r_timer == 16'd0);
  assign w_maj       = (r_smp2 & r_smp1) | (r_smp2 & w_rx_s) | (r_smp1 & w_rx_s);
  assign w_last_stop = (r_state == S_STOP) && w_tick && ((STOP_BITS == 1) || r_stop_cnt);
  // Break: all-zero data, zero parity bit (if any) and every stop bit low.
  assign w_brk       = w_last_stop && (r_shift == '0) && ((PARITY == 0) || !r_par_bit)
                       && !w_maj && ((STOP_BITS == 1) || r_ferr);

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk100) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (!w_rx_s) w_state_nxt = S_START;
      S_START:      if (w_tick) w_state_nxt = w_maj ? S_IDLE : S_DATA;
      S_DATA:       if (w_tick && (r_bit_cnt == LAST_BIT))
                      w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:     if (w_tick) w_state_nxt = S_STOP;
      S_STOP:       if (w_last_stop) w_state_nxt = (w_maj && !w_brk) ? S_IDLE : S_BREAK_WAIT;
      S_BREAK_WAIT: if (w_rx_s) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timer, majority samples, shift register and frame result capture.
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_timer     <= '0;
      r_smp2      <= 1'b1;
      r_smp1      <= 1'b1;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_par_err   <= 1'b0;
      r_ferr      <= 1'b0;
      r_wr_req    <= 1'b0;
      r_wr_entry  <= '0;
      r_break_det <= 1'b0;
    end else begin
      r_wr_req    <= 1'b0;
      r_break_det <= 1'b0;
      if (r_timer == 16'd2) r_smp2 <= w_rx_s;
      if (r_timer == 16'd1) r_smp1 <= w_rx_s;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_timer    <= TMR_HALF;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_bit  <= 1'b0;
            r_par_err  <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          r_timer <= w_tick ? TMR_BIT : r_timer - 16'd1;
          if (w_tick) begin
            case (r_state)
              S_START: r_bit_cnt <= '0;
              S_DATA: begin
                r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
              S_PARITY: begin
                r_par_bit <= w_maj;
                r_par_err <= (PARITY == 1) ? ~(^r_shift ^ w_maj) : (^r_shift ^ w_maj);
              end
              default: begin
                if (!w_maj) r_ferr <= 1'b1;
                r_stop_cnt <= 1'b1;
                if (w_last_stop) begin
                  if (w_brk) begin
                    r_break_det <= 1'b1;
                  end else begin
                    r_wr_req   <= 1'b1;
                    r_wr_entry <= {r_shift, r_ferr | ~w_maj, r_par_err};
                  end
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO control: pop only when valid; a write into a full FIFO is legal only with a pop.
  assign w_full       = (r_count == FULL_CNT);
  assign w_pop        = rd_en && r_valid;
  assign w_push       = r_wr_req && (!w_full || w_pop);
  assign w_ovr        = r_wr_req && w_full && !w_pop;
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

  // Next head: bypass the entry being written when it becomes the head.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_count_nxt == '0)                            w_head_nxt = '0;
    else if (w_push && (w_rd_ptr_nxt == r_wr_ptr))    w_head_nxt = r_wr_entry;
  end

  // FIFO storage.
  always_ff @(posedge clk100) begin
    if (w_push) r_mem[r_wr_ptr] <= r_wr_entry;
  end

  // FIFO pointers, count and registered outputs.
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_head    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_head    <= w_head_nxt;
      r_valid   <= (w_count_nxt != '0);
      r_overrun <= w_ovr;
    end
  end

  assign data       = r_head[EW-1:2];
  assign frame_err  = r_head[1];
  assign parity_err = r_head[0];
  assign valid      = r_valid;
  assign overrun    = r_overrun;
  assign break_det  = r_break_det;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg (CLK_DIV 16, 8E1, depth 4).
module tb_uart_rx_cfg;

  localparam int unsigned CLK_DIV    = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned PARITY     = 2;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HALF       = CLK_DIV / 2 + 1;
  localparam int unsigned NBITS      = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

  logic                 clk100 = 1'b0;
  logic                 reset  = 1'b1;
  logic                 rx     = 1'b1;
  logic                 rd_en  = 1'b0;
  logic [DATA_BITS-1:0] data;
  logic                 valid, frame_err, parity_err, overrun, break_det;

  typedef struct packed {
    logic [DATA_BITS-1:0] d;
    logic                 fe;
    logic                 pe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   ovr_seen = 0, brk_seen = 0, exp_ovr = 0, exp_brk = 0;
  int   pop_req_cnt = 0, pop_done_cnt = 0;
  bit   pop_en = 1'b0;

  uart_rx_cfg #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY(PARITY),
    .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk100(clk100), .reset(reset), .rx(rx), .rd_en(rd_en),
    .data(data), .valid(valid), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .break_det(break_det)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: counts pulses and pops/compares the FIFO head against the scoreboard.
  always @(negedge clk100) begin
    exp_t e;
    rd_en = 1'b0;
    if (overrun)   ovr_seen++;
    if (break_det) brk_seen++;
    if (!reset && valid && (pop_en || (pop_req_cnt > pop_done_cnt))) begin
      if (!pop_en) pop_done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_entry", int'(data), -1);
      end else begin
        e = exp_q.pop_front();
        check("data", int'(data), int'(e.d));
        check("frame_err", int'(frame_err), int'(e.fe));
        check("parity_err", int'(parity_err), int'(e.pe));
      end
      rd_en = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk100);
  endtask

  // Send one frame and record the outcome the receiver should produce.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit par_good,
                            input bit stop_hi, input int glitch_bit, input bit coinc_pop);
    logic [15:0] bv;
    int          n;
    logic        pbit;
    bit          brk;
    int          ones;
    ones = $countones(d);
    pbit = (PARITY == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (!par_good) pbit = ~pbit;
    bv = '0;
    n  = 0;
    bv[n] = 1'b0; n++;
    for (int i = 0; i < int'(DATA_BITS); i++) begin bv[n] = d[i]; n++; end
    if (PARITY != 0) begin bv[n] = pbit; n++; end
    for (int i = 0; i < int'(STOP_BITS); i++) begin bv[n] = stop_hi; n++; end

    brk = (d == '0) && ((PARITY == 0) || !pbit) && !stop_hi;
    if (brk) exp_brk++;
    else if (!pop_en && !coinc_pop && exp_q.size() >= FIFO_DEPTH) exp_ovr++;
    else exp_q.push_back('{d: d, fe: !stop_hi, pe: (PARITY != 0) && !par_good});

    @(negedge clk100);
    if (coinc_pop) begin
      fork
        begin
          repeat (3 + HALF + 1 + CLK_DIV * (NBITS - 1)) @(posedge clk100);
          #1 pop_req_cnt++;
        end
      join_none
    end
    for (int i = 0; i < n; i++) begin
      rx = bv[i];
      for (int c = 0; c < int'(CLK_DIV); c++) begin
        if (i == glitch_bit + 1 && c == int'(HALF))     rx = ~bv[i];
        if (i == glitch_bit + 1 && c == int'(HALF) + 1) rx = bv[i];
        @(negedge clk100);
      end
    end
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    pop_en = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || valid) && cyc < 2000) begin
      @(negedge clk100);
      cyc++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    idle(2);
    check({name, "_valid_low"}, int'(valid), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (4) @(negedge clk100);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_fe", int'(frame_err), 0);
    check("rst_pe", int'(parity_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_brk", int'(break_det), 0);
    reset = 1'b0;
    idle(2 * CLK_DIV);

    // Two back-to-back frames held in the FIFO, then drained.
    pop_en = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    check("t1_valid", int'(valid), 1);
    check("t1_head", int'(data), 'hA5);
    check("t1_flags", int'({frame_err, parity_err}), 0);
    wait_drain("t1");

    // Parity good and bad.
    send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1, -1, 1'b0);
    wait_drain("t2");

    // Low stop bit, line returned high, then a normal frame.
    send_frame(8'h55, 1'b1, 1'b0, -1, 1'b0);
    idle(2 * CLK_DIV);
    send_frame(8'h96, 1'b1, 1'b1, -1, 1'b0);
    wait_drain("t3");

    // Line held low for 12 bit times: exactly one break, no FIFO entry.
    exp_brk++;
    @(negedge clk100);
    rx = 1'b0;
    idle(12 * CLK_DIV);
    check("t4_break_count", brk_seen, exp_brk);
    check("t4_valid", int'(valid), 0);
    rx = 1'b1;
    idle(2 * CLK_DIV);
    check("t4_break_after", brk_seen, exp_brk);
    send_frame(8'h42, 1'b1, 1'b1, -1, 1'b0);
    wait_drain("t4");

    // Fill the FIFO and overflow it, then a pop coincident with a write when full.
    pop_en = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(DATA_BITS'(k), 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    check("t5_overrun", ovr_seen, exp_ovr);
    check("t5_head", int'(data), 1);
    send_frame(8'h06, 1'b1, 1'b1, -1, 1'b1);
    idle(4);
    check("t5_no_overrun_on_pop", ovr_seen, exp_ovr);
    check("t5_overrun_total", ovr_seen, 1);
    wait_drain("t5");

    // Start glitch, mid-bit glitch, reset mid-frame.
    @(negedge clk100);
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * CLK_DIV);
    send_frame(8'hC3, 1'b1, 1'b1, 2, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 5, 1'b0);
    wait_drain("t6_glitch");

    pop_en = 1'b0;
    send_frame(8'h33, 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    check("t6_pre_reset_valid", int'(valid), 1);
    @(negedge clk100);
    rx = 1'b0;
    idle(3 * CLK_DIV);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk100);
    check("t6_reset_valid", int'(valid), 0);
    idle(2);
    reset = 1'b0;
    exp_q.delete();
    idle(2 * CLK_DIV);
    pop_en = 1'b1;
    send_frame(8'h81, 1'b1, 1'b1, -1, 1'b0);
    wait_drain("t6_reset");

    // Randomised frames with random parity/stop errors, glitches and gaps.
    for (int k = 0; k < 40; k++) begin
      logic [DATA_BITS-1:0] d;
      bit                   pg, sh;
      int                   g;
      d  = DATA_BITS'($urandom);
      pg = ($urandom_range(0, 5) != 0);
      sh = ($urandom_range(0, 5) != 0);
      g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DATA_BITS - 1)) : -1;
      send_frame(d, pg, sh, g, 1'b0);
      if (!sh) idle(2 * CLK_DIV);
      else     idle(int'($urandom_range(0, 20)));
    end
    wait_drain("rand");

    check("final_overrun", ovr_seen, exp_ovr);
    check("final_break", brk_seen, exp_brk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver on the clk100 domain.
- Configurable data width, parity and stop bits.
- 2-flop input synchroniser and 3-sample majority vote at bit centre.
- Framing/parity error reporting and break detection.
- Small receive FIFO with valid/read handshake, so the terminal logic can drain bytes without losing back-to-back frames.

Parameters:
CLK_DIV, 868, clk100 cycles per bit (min 8, max 65535; 16-bit timer)
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries, power of 2, >= 2

Ports:
clk100  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
rd_en  in  1  pop request; honoured only when valid = 1
data  out  DATA_BITS  head-of-FIFO data, first-received bit in LSB
valid  out  1  FIFO not empty
frame_err  out  1  head entry had a low stop bit
parity_err  out  1  head entry had a parity mismatch (0 when PARITY = 0)
overrun  out  1  one-cycle pulse: completed frame dropped because FIFO full
break_det  out  1  one-cycle pulse: break condition detected

Behaviour:
- Reset: FSM = IDLE, FIFO empty, timer = 0, synchroniser flops = 1.
  - Outputs: valid = 0, data = 0, frame_err = 0, parity_err = 0, overrun = 0, break_det = 0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Synchroniser: rx passes through 2 flops to rx_s; all decisions use rx_s.
- Sampling: within each bit period, rx_s is sampled at timer = 2, 1 and 0. The majority of the three is the bit value, taken at timer = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: on rx_s = 0, timer <= CLK_DIV/2 + 1 and go to START.
  - START: at timer = 0, majority 0 -> DATA with timer <= CLK_DIV-1 and bit count = 0. Majority 1 -> IDLE (glitch rejected, nothing reported).
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit go to PARITY if PARITY != 0, else STOP.
  - PARITY: compute even parity over data XOR received parity bit.
    - Even mode: mismatch when the XOR result is 1.
    - Odd mode: mismatch when the XOR result is 0.
  - STOP: sample STOP_BITS stop bits. frame_err is set if any stop bit is 0.
    - At the final stop sample, normal case: write {data, frame_err, parity_err} to the FIFO. Return to IDLE if the final stop bit is 1, else BREAK_WAIT.
    - Break case: data = 0, parity bit 0 if present, and all stop bits 0. Pulse break_det on the next cycle, write nothing to the FIFO, go to BREAK_WAIT.
  - BREAK_WAIT: remain until rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Timer: down-counter reloaded with CLK_DIV-1 on each bit decision, so bit spacing is exactly CLK_DIV cycles.
- FIFO write and outputs:
  - Write occurs on the cycle after the final stop decision.
  - valid rises on the cycle after the write, so data/flags are registered outputs.
- FIFO read:
  - A pop on a cycle with rd_en = 1 and valid = 1 advances the head, with outputs updated the next cycle.
  - rd_en while valid = 0 is ignored.
- FIFO simultaneous events: a write and a pop in the same cycle are both performed; count is unchanged, and this is legal when full.
- Full FIFO: write with no pop -> frame dropped, overrun pulses for 1 cycle, and FIFO contents are untouched.
- Pointers: wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Data output width: data is exactly DATA_BITS wide; no padding.

Test Plan:
1. CLK_DIV = 16, 8N1: send 0xA5 then 0x3C back-to-back, rd_en = 0.
   -> valid = 1, data = 0xA5, both flags 0.
   -> Pop -> data = 0x3C next cycle; pop again -> valid = 0.
2. PARITY = 2: send 0x07 with parity bit 1 -> parity_err = 0. Send 0x07 with parity bit 0 -> parity_err = 1, data = 0x07.
3. Stop bit forced 0 on 0x55, then line returned high.
   -> Entry with frame_err = 1, data = 0x55; FSM passes through BREAK_WAIT and then accepts the next frame normally.
4. Hold rx low for 12 bit times.
   -> break_det pulses exactly once, FIFO stays empty, no further events until rx goes high.
5. FIFO_DEPTH = 4: send 5 frames 0x01..0x05 without popping.
   -> overrun pulses once on frame 5; pops return 0x01..0x04 in order.
   -> Also: a pop coincident with a write when full -> no overrun, count stays 4.
6. Start glitch of 3 cycles low -> nothing written.
   - Single-cycle glitch at a data bit centre -> bit value unchanged (majority vote).
   - reset asserted mid-DATA -> valid = 0 next cycle and the following clean frame 0x81 is received correctly.
